fir_output_requantizer: RTL and testbench

//  Consumer end of the FIR output stream. Tracks which FIR output cycles carry real samples,

---
 rtl/fir_output_requantizer.sv | 197 +++++++++++++++++++
 tb/tb_fir_output_requantizer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_requantizer.sv
// FIR output consumer: qualifies output cycles, rounds Q30 to Q15 with saturation,
// and buffers samples in a small FIFO behind a valid/ready sink interface.
module fir_output_requantizer #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int FIR_LAT    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  fir_data,
  input  logic             clear_flags,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             drop,
  output logic [15:0]      drop_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int QW = IN_W + 1 - FRAC_SHIFT;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IN_W:0]    RND_HALF = (IN_W+1)'(1) << (FRAC_SHIFT - 1);
  localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Valid delay line: matches in_valid to the FIR output it belongs to
  // ---------------------------------------------------------------------------
  logic [FIR_LAT-1:0] vld_sr_reg;
  logic [FIR_LAT-1:0] vld_sr_next;
  logic               qv;

  genvar gi;
  generate
    for (gi = 0; gi < FIR_LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_sr_next[gi] = in_valid;
      end else begin : g_tail
        assign vld_sr_next[gi] = vld_sr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr_reg <= '0;
    end else begin
      vld_sr_reg <= vld_sr_next;
    end
  end

  assign qv = vld_sr_reg[FIR_LAT-1];

  // ---------------------------------------------------------------------------
  // Round half-up then saturate; q fits in OUT_W iff its top bits are all equal
  // ---------------------------------------------------------------------------
  logic [IN_W:0]         rnd_sum;
  logic [QW-1:0]         rnd_q;
  logic [FRAC_SHIFT-1:0] rnd_frac_unused;
  logic [QW-OUT_W:0]     rnd_hi;
  logic                  rnd_fits;
  logic                  sat_hit;
  logic [OUT_W-1:0]      sat_val;

  assign rnd_sum         = {fir_data[IN_W-1], fir_data} + RND_HALF;
  assign rnd_q           = rnd_sum[IN_W:FRAC_SHIFT];
  assign rnd_frac_unused = rnd_sum[FRAC_SHIFT-1:0];
  assign rnd_hi          = rnd_q[QW-1:OUT_W-1];
  assign rnd_fits        = (&rnd_hi) | ~(|rnd_hi);
  assign sat_hit         = ~rnd_fits;
  assign sat_val         = rnd_fits ? rnd_q[OUT_W-1:0]
                                    : (rnd_q[QW-1] ? SAT_NEG : SAT_POS);

  // ---------------------------------------------------------------------------
  // Stage register: never stalls, so a full FIFO turns into a drop
  // ---------------------------------------------------------------------------
  logic             stg_v_reg;
  logic [OUT_W-1:0] stg_data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_v_reg    <= 1'b0;
      stg_data_reg <= '0;
    end else begin
      stg_v_reg <= qv;
      if (qv) begin
        stg_data_reg <= sat_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop_ev;

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == DEPTH_C);
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees the slot the incoming sample needs
  assign push      = stg_v_reg & (~full | pop);
  assign drop_ev   = stg_v_reg & ~push;
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= stg_data_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags: a new event beats clear_flags on the same edge
  // ---------------------------------------------------------------------------
  logic        overflow_reg, overflow_next;
  logic        drop_reg;
  logic [15:0] drop_count_reg, drop_count_next;
  logic        ovf_ev;

  assign ovf_ev = qv & sat_hit;

  always_comb begin
    overflow_next   = overflow_reg;
    drop_count_next = drop_count_reg;
    if (ovf_ev) begin
      overflow_next = 1'b1;
    end else if (clear_flags) begin
      overflow_next = 1'b0;
    end
    if (drop_ev) begin
      if (clear_flags) begin
        drop_count_next = 16'd1;
      end else if (drop_count_reg != 16'hFFFF) begin
        drop_count_next = drop_count_reg + 16'd1;
      end
    end else if (clear_flags) begin
      drop_count_next = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg   <= 1'b0;
      drop_reg       <= 1'b0;
      drop_count_reg <= 16'd0;
    end else begin
      overflow_reg   <= overflow_next;
      drop_reg       <= drop_ev;
      drop_count_reg <= drop_count_next;
    end
  end

  assign overflow   = overflow_reg;
  assign drop       = drop_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed and random checks of fir_output_requantizer against an arithmetic reference model.
module tb_fir_output_requantizer;

  localparam int FIR_LAT    = 6;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] fir_data;
  logic        clear_flags;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        drop;
  logic [15:0] drop_count;

  fir_output_requantizer #(
    .IN_W(32), .OUT_W(16), .FRAC_SHIFT(15), .FIR_LAT(FIR_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .fir_data(fir_data),
    .clear_flags(clear_flags), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .drop(drop), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int drops_seen = 0;

  // Reference model state
  logic [15:0] m_fifo[$];
  bit          hq[$];
  bit          m_pend_v;
  logic [15:0] m_pend_d;
  bit          m_ovf;
  bit          m_drop;
  int          m_dc;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          valid_cyc[$];
  logic [31:0] bq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round half-up toward +inf, then clamp to Q15
  task automatic ref_q15(input logic [31:0] x, output logic [15:0] r, output bit sat);
    longint v;
    longint q;
    v = longint'($signed(x)) + 64'sd16384;
    if (v >= 0) q = v / 32768;
    else        q = -((-v + 32767) / 32768);
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767; sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; sat = 1'b1;
    end
    r = 16'(q);
  endtask

  task automatic m_reset();
    m_fifo.delete();
    hq.delete();
    for (int i = 0; i < FIR_LAT; i++) hq.push_back(1'b0);
    m_pend_v = 1'b0;
    m_pend_d = '0;
    m_ovf    = 1'b0;
    m_drop   = 1'b0;
    m_dc     = 0;
  endtask

  task automatic model_edge(input logic iv, input logic [31:0] fd, input logic rdy, input logic clr);
    bit qv;
    bit sat;
    bit drop_ev;
    logic [15:0] r;
    qv = hq[0];
    void'(hq.pop_front());
    hq.push_back(iv);
    drop_ev = 1'b0;
    sat = 1'b0;
    if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
    if (m_pend_v) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_pend_d);
      else drop_ev = 1'b1;
    end
    m_pend_v = qv;
    if (qv) begin
      ref_q15(fd, r, sat);
      m_pend_d = r;
    end
    if (qv && sat) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    if (drop_ev) m_dc = clr ? 1 : ((m_dc < 65535) ? m_dc + 1 : 65535);
    else if (clr) m_dc = 0;
    m_drop = drop_ev;
  endtask

  // One clock: drive at edge+1, check mid-cycle, then advance the model
  task automatic cycle(input logic iv, input logic [31:0] fd, input logic rdy, input logic clr);
    in_valid = iv; fir_data = fd; out_ready = rdy; clear_flags = clr;
    #5;
    chk("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("out_data", 32'(out_data), 32'(m_fifo[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop", 32'(drop), 32'(m_drop));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (out_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      if (rdy) obs_q.push_back(out_data);
    end
    if (drop === 1'b1) drops_seen++;
    @(posedge clk);
    model_edge(iv, fd, rdy, clr);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, rdy, 1'b0);
  endtask

  // Sends bq: in_valid for each sample, data FIR_LAT cycles later
  task automatic burst(input logic rdy, input int flip_at);
    int n;
    logic r;
    n = bq.size();
    for (int i = 0; i < n + FIR_LAT + 1; i++) begin
      r = (i == flip_at) ? ~rdy : rdy;
      cycle(i < n, (i >= FIR_LAT && i - FIR_LAT < n) ? bq[i-FIR_LAT] : $urandom, r, 1'b0);
    end
    bq.delete();
  endtask

  task automatic check_obs(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
  endtask

  task automatic do_async_reset();
    in_valid = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    cyc += 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] edge_vals [6];
  logic [31:0] fd;
  int          c0;
  int          dc_save;

  initial begin
    edge_vals = '{32'h3FFF_BFFF, 32'h3FFF_C000, 32'hBFFF_C000,
                  32'hBFFF_BFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    reset = 1'b0; in_valid = 1'b0; fir_data = '0; clear_flags = 1'b0; out_ready = 1'b0;
    m_reset();
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_data", 32'(out_data), 32'd0);
    chk("init_overflow", 32'(overflow), 32'd0);
    chk("init_drop", 32'(drop), 32'd0);
    chk("init_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Rounding
    obs_q.delete();
    bq = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF};
    burst(1'b1, -1);
    idle(3, 1'b1);
    exp_q = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    check_obs("t1_round");
    chk("t1_overflow", 32'(overflow), 32'd0);

    // Saturation and clear_flags
    bq = '{32'h4000_0000, 32'hC000_0000};
    burst(1'b1, -1);
    idle(3, 1'b1);
    exp_q = '{16'h7FFF, 16'h8000};
    check_obs("t2_sat");
    chk("t2_overflow_set", 32'(overflow), 32'd1);
    cycle(1'b0, $urandom, 1'b1, 1'b1);
    chk("t2_overflow_clr", 32'(overflow), 32'd0);

    // Latency
    valid_cyc.delete();
    obs_q.delete();
    c0 = cyc;
    cycle(1'b1, $urandom, 1'b1, 1'b0);
    idle(FIR_LAT - 1, 1'b1);
    cycle(1'b0, 32'h0123_8000, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("t3_valid_cycles", 32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() > 0) chk("t3_latency", 32'(valid_cyc[0] - c0), 32'(FIR_LAT + 2));
    exp_q = '{16'h0247};
    check_obs("t3_data");

    // Backpressure with drops
    cycle(1'b0, $urandom, 1'b1, 1'b1);
    drops_seen = 0;
    for (int i = 1; i <= 6; i++) bq.push_back(32'(i) << 15);
    burst(1'b0, -1);
    idle(2, 1'b0);
    chk("t4_drop_pulses", 32'(drops_seen), 32'd2);
    chk("t4_drop_count", 32'(drop_count), 32'd2);
    obs_q.delete();
    idle(6, 1'b1);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    check_obs("t4_order");
    chk("t4_empty", 32'(out_valid), 32'd0);

    // Full FIFO with a pop on the arrival edge of a fifth sample
    drops_seen = 0;
    dc_save = int'(drop_count);
    obs_q.delete();
    for (int i = 10; i <= 14; i++) bq.push_back(32'(i) << 15);
    burst(1'b0, 5 + FIR_LAT);
    idle(1, 1'b0);
    chk("t5_no_drop", 32'(drops_seen), 32'd0);
    chk("t5_drop_count", 32'(drop_count), 32'(dc_save));
    idle(6, 1'b1);
    exp_q = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14};
    check_obs("t5_order");
    chk("t5_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset with three samples buffered
    bq = '{32'h4000_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_8000, 32'h0002_0000};
    burst(1'b0, -1);
    idle(2, 1'b0);
    cycle(1'b0, $urandom, 1'b1, 1'b0);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_overflow", 32'(overflow), 32'd1);
    do_async_reset();
    obs_q.delete();
    idle(FIR_LAT + 3, 1'b1);
    chk("t6_no_stale", 32'(obs_q.size()), 32'd0);
    bq = '{32'h0002_8000};
    burst(1'b1, -1);
    idle(2, 1'b1);
    exp_q = '{16'd5};
    check_obs("t6_fresh");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       fd = $urandom;
        1:       fd = 32'($urandom_range(0, 32'h01FF_FFFF)) - 32'h0100_0000;
        2:       fd = ($urandom & 32'hFFFF_8000) | (($urandom_range(0, 1) == 0) ? 32'h4000 : 32'h3FFF);
        default: fd = edge_vals[$urandom_range(0, 5)] + 32'($urandom_range(0, 2)) - 32'd1;
      endcase
      cycle(1'($urandom_range(0, 1)), fd, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end
    idle(FIR_LAT + FIFO_DEPTH + 4, 1'b1);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
